// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage of the RV32 core, wrapped around an external
// combinational ALU.
//   S1 latches the decoded operands from ID and drives the ALU.
//   S2 registers the ALU result, destination and branch outcome for MEM/WB.
//   Both stages use valid/ready handshakes.
//
// Ports
//   clk, rst_n           core clock; asynchronous active-low reset
//   flush                synchronous squash of S1 and S2, wins over everything
//   in_valid / in_ready  ID handshake
//   in_*                 decoded instruction: ALU op, source addresses and data,
//                        immediate, immediate select, PC, branch kind, dest
//   alu_function,
//   operand_a/b          drive the ALU (function is 0 whenever S1 is empty)
//   alu_result/alu_zero  ALU response
//   out_valid/out_ready  MEM/WB handshake
//   out_*                registered result, destination, branch outcome/target
//
// Configuration
//   EX_FORWARD_EN  defined: S2 result is forwarded to S1 operands, no interlock.
//                  undefined: no forwarding; in_ready is held low while an S1 or
//                  S2 entry writes a register the offered instruction reads.
module alu_exec_stage #(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 5,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] in_alu_function,
  input  logic [REG_W-1:0]  in_rs1_addr,
  input  logic [REG_W-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [1:0]        in_br,
  input  logic [REG_W-1:0]  in_rd_addr,
  input  logic              in_rd_we,
  output logic [FUNC_W-1:0] alu_function,
  output logic [XLEN-1:0]   operand_a,
  output logic [XLEN-1:0]   operand_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_W-1:0]  out_rd_addr,
  output logic              out_rd_we,
  output logic              out_br_taken,
  output logic [XLEN-1:0]   out_br_target
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } br_e;

  // S1 state
  logic              s1_valid;
  logic [FUNC_W-1:0] s1_func;
  logic [XLEN-1:0]   s1_rs1_data;
  logic [XLEN-1:0]   s1_rs2_data;
  logic [XLEN-1:0]   s1_imm;
  logic              s1_use_imm;
  logic [XLEN-1:0]   s1_pc;
  br_e               s1_br;
  logic [REG_W-1:0]  s1_rd;
  logic              s1_rd_we;

  // S2 state (the out_* registers hold the payload)
  logic              s2_valid;

  logic              s2_load;
  logic              br_squash;
  logic              accept;
  logic              hazard;
  logic              fwd_a;
  logic              fwd_b;
  logic              br_taken;
  logic [XLEN-1:0]   br_target;

  assign out_valid = s2_valid;

`ifdef EX_FORWARD_EN
  logic [REG_W-1:0] s1_rs1_addr;
  logic [REG_W-1:0] s1_rs2_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rs1_addr <= '0;
      s1_rs2_addr <= '0;
    end else if (accept) begin
      s1_rs1_addr <= in_rs1_addr;
      s1_rs2_addr <= in_rs2_addr;
    end
  end

  // out_rd_we is already cleared for taken branches, so they never forward.
  always_comb begin
    fwd_a  = s2_valid & out_rd_we & (out_rd_addr != '0) & (out_rd_addr == s1_rs1_addr);
    fwd_b  = s2_valid & out_rd_we & (out_rd_addr != '0) & (out_rd_addr == s1_rs2_addr)
             & ~s1_use_imm;
    hazard = 1'b0;
  end
`else
  function automatic logic raw_dep(input logic             v,
                                   input logic             we,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return v & we & (rd != '0) & (rd == rs);
  endfunction

  // The S2 check stays active in the cycle S2 retires: the register file
  // only holds the value once MEM/WB has taken it.
  always_comb begin
    fwd_a  = 1'b0;
    fwd_b  = 1'b0;
    hazard = raw_dep(s1_valid, s1_rd_we, s1_rd, in_rs1_addr)
           | raw_dep(s2_valid, out_rd_we, out_rd_addr, in_rs1_addr)
           | (~in_use_imm & (raw_dep(s1_valid, s1_rd_we, s1_rd, in_rs2_addr)
                           | raw_dep(s2_valid, out_rd_we, out_rd_addr, in_rs2_addr)));
  end
`endif

  always_comb begin
    br_squash    = s2_valid & out_ready & out_br_taken;
    s2_load      = s1_valid & (~s2_valid | out_ready);
    in_ready     = (~s1_valid | s2_load) & ~br_squash & ~hazard;
    accept       = in_valid & in_ready & ~flush;

    alu_function = s1_valid ? s1_func : '0;
    operand_a    = fwd_a ? out_result : s1_rs1_data;
    operand_b    = s1_use_imm ? s1_imm : (fwd_b ? out_result : s1_rs2_data);

    br_taken     = s1_valid & (((s1_br == BR_EQ) & alu_zero) | ((s1_br == BR_NE) & ~alu_zero));
    br_target    = s1_pc + s1_imm;
  end

  // S1: a taken branch leaving S2 kills the younger S1 entry instead of
  // letting it move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_func     <= '0;
      s1_rs1_data <= '0;
      s1_rs2_data <= '0;
      s1_imm      <= '0;
      s1_use_imm  <= 1'b0;
      s1_pc       <= '0;
      s1_br       <= BR_NONE;
      s1_rd       <= '0;
      s1_rd_we    <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_func     <= in_alu_function;
      s1_rs1_data <= in_rs1_data;
      s1_rs2_data <= in_rs2_data;
      s1_imm      <= in_imm;
      s1_use_imm  <= in_use_imm;
      s1_pc       <= in_pc;
      s1_br       <= br_e'(in_br);
      s1_rd       <= in_rd_addr;
      s1_rd_we    <= in_rd_we;
    end else if (s2_load | br_squash) begin
      s1_valid <= 1'b0;
    end
  end

  // S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      out_result    <= '0;
      out_rd_addr   <= '0;
      out_rd_we     <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load & ~br_squash) begin
      s2_valid      <= 1'b1;
      out_result    <= alu_result;
      out_rd_addr   <= s1_rd;
      out_rd_we     <= s1_rd_we & ~br_taken;
      out_br_taken  <= br_taken;
      out_br_target <= br_target;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  typedef struct {
    logic [4:0]  func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  br;
    logic [31:0] pc;
  } instr_t;

  localparam logic [4:0] F_ADD = 5'd1, F_SUB = 5'd2, F_XOR = 5'd6, F_OR = 5'd9, F_AND = 5'd11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  alu_function;
  logic [31:0] operand_a, operand_b, alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we, out_br_taken;
  instr_t      cur;

  logic [31:0] rf [32];
  instr_t      sb [$];
  int          compared = 0;
  int          mismatched = 0;
  logic        hold = 1'b0;
  logic [70:0] held;
  logic        last_acc, last_in_ready, last_ret;
  logic [4:0]  ret_rd;
  logic [31:0] ret_res;

  always #5 clk = ~clk;

  // Reference ALU: also serves as the environment's ALU for the DUT.
  function automatic logic [31:0] alu_ref(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a << b[4:0];
      5'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5:    return (a < b) ? 32'd1 : 32'd0;
      5'd6:    return a ^ b;
      5'd7:    return a >> b[4:0];
      5'd8:    return $unsigned($signed(a) >>> b[4:0]);
      5'd9:    return a | b;
      5'd10:   return b;
      5'd11:   return a & b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_function, operand_a, operand_b);
  assign alu_zero   = (alu_result == 32'd0);

  alu_exec_stage #(.XLEN(32), .FUNC_W(5), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_function(cur.func), .in_rs1_addr(cur.rs1), .in_rs2_addr(cur.rs2),
    .in_rs1_data(rs1_data), .in_rs2_data(rs2_data), .in_imm(cur.imm),
    .in_use_imm(cur.use_imm), .in_pc(cur.pc), .in_br(cur.br),
    .in_rd_addr(cur.rd), .in_rd_we(cur.we),
    .alu_function(alu_function), .operand_a(operand_a), .operand_b(operand_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target)
  );

  function automatic instr_t mk(input logic [4:0] f, input logic [4:0] r1, input logic [4:0] r2,
                                input logic ui, input logic [31:0] imm, input logic [4:0] rd,
                                input logic we, input logic [1:0] br, input logic [31:0] pc);
    instr_t t;
    t.func = f; t.rs1 = r1; t.rs2 = r2; t.use_imm = ui; t.imm = imm;
    t.rd = rd; t.we = we; t.br = br; t.pc = pc;
    return t;
  endfunction

  // One clock: retire against the architectural model (program order, register
  // file updated at retirement, taken branch kills younger accepted work), then
  // present register-file data with write-before-read, then record acceptance.
  task automatic step();
    logic ret, taken;
    logic [31:0] a, b, res, tgt;
    instr_t h;
    #1;
    ret = out_valid & out_ready & ~flush;
    last_ret = 1'b0;
    if (hold) begin
      compared++;
      if ({out_result, out_rd_addr, out_rd_we, out_br_taken, out_br_target} !== held) begin
        mismatched++;
        $display("FAIL hold_stable: got %h, required %h",
                 {out_result, out_rd_addr, out_rd_we, out_br_taken, out_br_target}, held);
      end
    end
    hold = out_valid & ~out_ready & ~flush;
    held = {out_result, out_rd_addr, out_rd_we, out_br_taken, out_br_target};
    if (ret) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL spurious_output: got result %h rd %0d, required no output", out_result, out_rd_addr);
      end else begin
        h     = sb.pop_front();
        a     = rf[h.rs1];
        b     = h.use_imm ? h.imm : rf[h.rs2];
        res   = alu_ref(h.func, a, b);
        taken = ((h.br == 2'b01) && (res == 0)) || ((h.br == 2'b10) && (res != 0));
        tgt   = h.pc + h.imm;
        if (out_result !== res) begin
          mismatched++;
          $display("FAIL result: got %h, required %h", out_result, res);
        end
        compared++;
        if (out_rd_addr !== h.rd) begin
          mismatched++;
          $display("FAIL rd_addr: got %0d, required %0d", out_rd_addr, h.rd);
        end
        compared++;
        if (out_rd_we !== (h.we & ~taken)) begin
          mismatched++;
          $display("FAIL rd_we: got %b, required %b", out_rd_we, h.we & ~taken);
        end
        compared++;
        if (out_br_taken !== taken) begin
          mismatched++;
          $display("FAIL br_taken: got %b, required %b", out_br_taken, taken);
        end
        compared++;
        if (out_br_target !== tgt) begin
          mismatched++;
          $display("FAIL br_target: got %h, required %h", out_br_target, tgt);
        end
        if (taken) begin
          compared++;
          if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL in_ready_on_squash: got %b, required 0", in_ready);
          end
          sb.delete();
        end else if (h.we && h.rd != 5'd0) begin
          rf[h.rd] = res;
        end
        last_ret = 1'b1;
        ret_rd   = h.rd;
        ret_res  = out_result;
      end
    end
    rs1_data = rf[cur.rs1];
    rs2_data = rf[cur.rs2];
    #1;
    last_in_ready = in_ready;
    last_acc      = in_valid & in_ready & ~flush;
    if (last_acc) sb.push_back(cur);
    if (flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    cur = mk(5'd0, 5'd0, 5'd0, 1'b0, '0, 5'd0, 1'b0, 2'b00, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    hold = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    compared++;
    if ({out_valid, out_result, out_rd_we, out_br_taken, in_ready, alu_function} !==
        {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b res=%h we=%b tk=%b rdy=%b fn=%0d, required 0/0/0/0/1/0",
               out_valid, out_result, out_rd_we, out_br_taken, in_ready, alu_function);
    end
    @(negedge clk);
  endtask

  task automatic test_add_stream();
    rf[1] = 32'd5;
    out_ready = 1'b1;
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd7, 5'd2, 1'b1, 2'b00, 32'h40);
    in_valid = 1'b1;
    step();
    compared++;
    if (last_acc !== 1'b1 || out_valid !== 1'b0 || alu_function !== F_ADD) begin
      mismatched++;
      $display("FAIL add_accept: got acc=%b v=%b fn=%0d, required 1/0/1", last_acc, out_valid, alu_function);
    end
    in_valid = 1'b0;
    step();
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'd12) begin
      mismatched++;
      $display("FAIL add_latency: got v=%b res=%h, required 1/0000000c", out_valid, out_result);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, $urandom, 5'(10 + i), 1'b1, 2'b00, 32'h44 + 32'(4 * i));
      step();
      compared++;
      if (last_acc !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
        mismatched++;
        $display("FAIL add_throughput: got acc=%b v=%b at %0d, required 1/1", last_acc, out_valid, i);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a;
    rf[1] = 32'd5;
    exp_a = alu_ref(F_ADD, 32'd5, 32'd100);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd100, 5'd20, 1'b1, 2'b00, 32'h80);
    step();
    cur = mk(F_XOR, 5'd1, 5'd0, 1'b1, 32'h55, 5'd21, 1'b1, 2'b00, 32'h84);
    step();
    compared++;
    if (last_acc !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_fill: got acc=%b, required 1", last_acc);
    end
    cur = mk(F_OR, 5'd1, 5'd0, 1'b1, 32'hF0, 5'd22, 1'b1, 2'b00, 32'h88);
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (last_in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== exp_a) begin
        mismatched++;
        $display("FAIL bp_hold: got rdy=%b v=%b res=%h, required 0/1/%h", last_in_ready, out_valid, out_result, exp_a);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_acc) break;
    end
    compared++;
    if (last_acc !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: got acc=%b, required 1", last_acc);
    end
    drain();
  endtask

  task automatic test_raw();
    int stalls = 0;
    logic seen = 1'b0;
    rf[1] = 32'd1; rf[2] = 32'd2; rf[3] = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cur = mk(F_ADD, 5'd1, 5'd2, 1'b0, '0, 5'd3, 1'b1, 2'b00, 32'h200);
    step();
    cur = mk(F_SUB, 5'd3, 5'd1, 1'b0, '0, 5'd4, 1'b1, 2'b00, 32'h204);
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_ret && ret_rd == 5'd4) seen = 1'b1;
      if (last_acc) break;
      stalls++;
    end
    in_valid = 1'b0;
    compared++;
`ifdef EX_FORWARD_EN
    if (stalls != 0) begin
      mismatched++;
      $display("FAIL raw_stalls: got %0d, required 0", stalls);
    end
`else
    if (stalls < 1) begin
      mismatched++;
      $display("FAIL raw_stalls: got %0d, required at least 1", stalls);
    end
`endif
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (last_ret && ret_rd == 5'd4) seen = 1'b1;
    end
    compared++;
    if (!seen || ret_res !== 32'd2) begin
      mismatched++;
      $display("FAIL raw_result: got seen=%b res=%h, required 1/00000002", seen, ret_res);
    end
    drain();
  endtask

  task automatic test_branch();
    rf[9] = 32'h1234;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cur = mk(F_SUB, 5'd9, 5'd9, 1'b0, 32'h20, 5'd5, 1'b1, 2'b01, 32'h100);
    step();
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd1, 5'd6, 1'b1, 2'b00, 32'h104);
    step();
    in_valid = 1'b0;
    #1;
    compared++;
    if ({out_valid, out_br_taken, out_br_target, out_rd_we, in_ready} !== {1'b1, 1'b1, 32'h120, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL beq_out: got v=%b tk=%b tgt=%h we=%b rdy=%b, required 1/1/120/0/0",
               out_valid, out_br_taken, out_br_target, out_rd_we, in_ready);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL beq_squash: got v=%b, required 0", out_valid);
      end
      step();
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(F_AND, 5'd1, 5'd0, 1'b1, 32'hFFFF, 5'd7, 1'b1, 2'b00, 32'h300);
    step();
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd9, 5'd8, 1'b1, 2'b00, 32'h304);
    step();
    cur = mk(F_OR, 5'd1, 5'd0, 1'b1, 32'd3, 5'd9, 1'b1, 2'b00, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    compared++;
    if (out_valid !== 1'b0 || alu_function !== 5'd0) begin
      mismatched++;
      $display("FAIL flush_empty: got v=%b fn=%0d, required 0/0", out_valid, alu_function);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_emit: got v=%b, required 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    rf[1] = 32'd5;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd100, 5'd20, 1'b1, 2'b00, 32'h400);
    step();
    cur = mk(F_ADD, 5'd1, 5'd0, 1'b1, 32'd50, 5'd21, 1'b1, 2'b00, 32'h404);
    step();
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got v=%b res=%h, required 0/0", out_valid, out_result);
    end
    sb.delete();
    hold = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_release: got rdy=%b v=%b res=%h, required 1/0/0", in_ready, out_valid, out_result);
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_random();
    logic [4:0] fsel [6];
    fsel[0] = 5'd0; fsel[1] = F_ADD; fsel[2] = F_SUB; fsel[3] = F_XOR; fsel[4] = F_OR; fsel[5] = F_AND;
    for (int n = 0; n < 400; n++) begin
      cur.func    = fsel[$urandom_range(0, 5)];
      cur.rs1     = 5'($urandom_range(0, 5));
      cur.rs2     = 5'($urandom_range(0, 5));
      cur.use_imm = 1'($urandom);
      cur.imm     = ($urandom % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cur.rd      = 5'($urandom_range(0, 5));
      cur.we      = 1'($urandom);
      cur.pc      = $urandom;
      cur.br      = 2'b00;
      case ($urandom_range(0, 9))
        0: begin cur.br = 2'b01; cur.func = F_SUB; cur.use_imm = 1'b0;
                 if ($urandom % 2 == 0) cur.rs2 = cur.rs1; end
        1: begin cur.br = 2'b10; cur.func = F_SUB; cur.use_imm = 1'b0;
                 if ($urandom % 2 == 0) cur.rs2 = cur.rs1; end
        default: ;
      endcase
      in_valid  = ($urandom % 4 != 0);
      flush     = ($urandom % 50 == 0);
      out_ready = flush ? 1'b0 : ($urandom % 4 != 0);
      step();
    end
    drain();
  endtask

  initial begin
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    cur = mk(5'd0, 5'd0, 5'd0, 1'b0, '0, 5'd0, 1'b0, 2'b00, '0);
    test_reset();
    test_add_stream();
    test_backpressure();
    test_raw();
    test_branch();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, required completion");
    $fatal(1);
  end

endmodule
